// File: rtl/fifo_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fifo_tx_scheduler
// Brief    : Drains one frame of FIFO bytes into the UART transmitter,
//            wrapped in header/trailer bytes, on receipt of a capture command.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_tx_scheduler #(
    parameter int unsigned FRAME_BYTES = 16,
    parameter logic [7:0]  HDR_BYTE    = 8'hAA,
    parameter logic [7:0]  TRL_BYTE    = 8'h55,
    parameter logic [7:0]  CMD_CAPTURE = 8'h43,
    parameter logic [7:0]  CMD_ABORT   = 8'h53
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_dout,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       capture_en,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned       CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0]  C_FRAME_CNT = CNT_W'(FRAME_BYTES);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HDR       = 4'd1,
        S_HDR_ACK   = 4'd2,
        S_HDR_WAIT  = 4'd3,
        S_RD        = 4'd4,
        S_LATCH     = 4'd5,
        S_SEND      = 4'd6,
        S_SEND_ACK  = 4'd7,
        S_SEND_WAIT = 4'd8,
        S_TRL       = 4'd9,
        S_TRL_ACK   = 4'd10,
        S_TRL_WAIT  = 4'd11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_abort;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic             r_capture_en;
    logic             r_frame_done;

    logic             w_cmd_capture;
    logic             w_cmd_abort;
    logic             w_abortable;
    logic             w_accept;
    logic             w_rd_en;
    logic             w_latch;
    logic             w_tx_go;
    logic [7:0]       w_tx_byte;
    logic             w_inc;
    logic             w_trl;
    logic             w_done;

    assign w_cmd_capture = rx_valid && (rx_data == CMD_CAPTURE);
    assign w_cmd_abort   = rx_valid && (rx_data == CMD_ABORT);
    assign w_abortable   = (r_state >= S_HDR) && (r_state <= S_SEND_WAIT);
    assign w_accept      = (r_state == S_IDLE) && w_cmd_capture;

    // Commands are evaluated against the current state; capture while busy is dropped.
    always_comb begin
        w_next    = r_state;
        w_rd_en   = 1'b0;
        w_latch   = 1'b0;
        w_tx_go   = 1'b0;
        w_tx_byte = r_tx_data;
        w_inc     = 1'b0;
        w_trl     = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE:      if (w_cmd_capture) w_next = S_HDR;
            S_HDR: begin
                if (!tx_busy) begin
                    w_tx_go   = 1'b1;
                    w_tx_byte = HDR_BYTE;
                    w_next    = S_HDR_ACK;
                end
            end
            S_HDR_ACK:   w_next = S_HDR_WAIT;
            S_HDR_WAIT:  if (!tx_busy) w_next = S_RD;
            S_RD: begin
                if (r_abort) begin
                    w_next = S_TRL;
                end else if (!fifo_empty) begin
                    w_rd_en = 1'b1;
                    w_next  = S_LATCH;
                end
            end
            S_LATCH: begin
                w_latch = 1'b1;
                w_next  = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    w_tx_go = 1'b1;
                    w_inc   = 1'b1;
                    w_next  = S_SEND_ACK;
                end
            end
            S_SEND_ACK:  w_next = S_SEND_WAIT;
            S_SEND_WAIT: begin
                if (!tx_busy) begin
                    w_next = (r_abort || (r_cnt == C_FRAME_CNT)) ? S_TRL : S_RD;
                end
            end
            S_TRL: begin
                if (!tx_busy) begin
                    w_tx_go   = 1'b1;
                    w_tx_byte = TRL_BYTE;
                    w_trl     = 1'b1;
                    w_next    = S_TRL_ACK;
                end
            end
            S_TRL_ACK:   w_next = S_TRL_WAIT;
            S_TRL_WAIT: begin
                if (!tx_busy) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_abort      <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_capture_en <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_tx_start   <= w_tx_go;
            r_frame_done <= w_done;

            // tx_data and tx_start are registered together so they leave in the same cycle.
            if (w_tx_go) begin
                r_tx_data <= w_tx_byte;
            end else if (w_latch) begin
                r_tx_data <= fifo_dout;
            end

            if (w_accept) begin
                r_capture_en <= 1'b1;
            end else if (w_trl) begin
                r_capture_en <= 1'b0;
            end

            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_inc && (r_cnt != C_FRAME_CNT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_done || (r_state == S_IDLE)) begin
                r_abort <= 1'b0;
            end else if (w_cmd_abort && w_abortable) begin
                r_abort <= 1'b1;
            end
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign capture_en = r_capture_en;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_tx_scheduler
// Brief    : Directed bench with a FIFO model and a UART-tx busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'h00;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       capture_en;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    fifo_tx_scheduler #(
        .FRAME_BYTES (4),
        .HDR_BYTE    (8'hAA),
        .TRL_BYTE    (8'h55),
        .CMD_CAPTURE (8'h43),
        .CMD_ABORT   (8'h53)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .capture_en (capture_en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // FIFO model: data valid the cycle after the read strobe; not cleared by reset.
    logic [7:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_n = 0;
    int underflow = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_n <= rd_n + 1;
            if (wr_ptr == rd_ptr) begin
                underflow <= underflow + 1;
            end else begin
                fifo_dout <= fmem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Transmitter model: busy rises tx_delay cycles late and stays up tx_len cycles.
    int tx_delay = 0;
    int tx_len = 3;
    int m_dly = 0;
    int m_len = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy <= 1'b0;
            m_dly = 0;
            m_len = 0;
        end else begin
            if (tx_start) begin
                m_dly = tx_delay;
                m_len = tx_len;
            end
            if (m_dly > 0) begin
                m_dly = m_dly - 1;
                tx_busy <= 1'b0;
            end else if (m_len > 0) begin
                m_len = m_len - 1;
                tx_busy <= 1'b1;
            end else begin
                tx_busy <= 1'b0;
            end
        end
    end

    logic [7:0] tx_log [0:255];
    logic       cap_log [0:255];
    int  tx_n = 0;
    int  fd_n = 0;
    int  start_busy = 0;
    int  unstable = 0;
    bit  chk_stable = 1'b0;
    always @(negedge clk) begin
        if (tx_start) begin
            tx_log[tx_n]  = tx_data;
            cap_log[tx_n] = capture_en;
            tx_n = tx_n + 1;
            if (tx_busy) start_busy = start_busy + 1;
        end else if (chk_stable && tx_busy && (tx_n > 0) && (tx_data !== tx_log[tx_n-1])) begin
            unstable = unstable + 1;
        end
        if (frame_done) fd_n = fd_n + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_done(input string name, input int max);
        int k = 0;
        while (!frame_done && k < max) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, max);
        end
        tick(2);
    endtask

    task automatic wait_tx(input string name, input int target, input int max);
        int k = 0;
        while (tx_n < target && k < max) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (tx_n < target) begin
            errors++;
            $display("FAIL %s: tx count got %0d need %0d", name, tx_n, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks += 6;
        if (tx_start !== 1'b0)   begin errors++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
        if (capture_en !== 1'b0) begin errors++; $display("FAIL rst_capture_en: got %b want 0", capture_en); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        if (tx_data !== 8'h00)   begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic_frame();
        logic [7:0] want [6];
        int t0 = tx_n;
        int r0 = rd_n;
        int f0 = fd_n;
        int s0 = start_busy;
        int u0 = unstable;
        want = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tx_delay = 0; tx_len = 3; chk_stable = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        checks++;
        if (capture_en !== 1'b0) begin errors++; $display("FAIL basic_cap_pre: got %b want 0", capture_en); end
        send_cmd(8'h43);
        checks++;
        if (capture_en !== 1'b1) begin errors++; $display("FAIL basic_cap_rise: got %b want 1", capture_en); end
        wait_done("basic", 300);
        checks++;
        if (tx_n - t0 !== 6) begin errors++; $display("FAIL basic_count: got %0d want 6", tx_n - t0); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tx_log[t0+i] !== want[i]) begin
                errors++; $display("FAIL basic_byte%0d: got %h want %h", i, tx_log[t0+i], want[i]);
            end
        end
        checks += 8;
        if (cap_log[t0] !== 1'b1)   begin errors++; $display("FAIL basic_cap_hdr: got %b want 1", cap_log[t0]); end
        if (cap_log[t0+4] !== 1'b1) begin errors++; $display("FAIL basic_cap_last: got %b want 1", cap_log[t0+4]); end
        if (cap_log[t0+5] !== 1'b0) begin errors++; $display("FAIL basic_cap_trl: got %b want 0", cap_log[t0+5]); end
        if (rd_n - r0 !== 4)        begin errors++; $display("FAIL basic_reads: got %0d want 4", rd_n - r0); end
        if (fd_n - f0 !== 1)        begin errors++; $display("FAIL basic_done: got %0d want 1", fd_n - f0); end
        if (start_busy !== s0)      begin errors++; $display("FAIL basic_start_busy: got %0d want %0d", start_busy, s0); end
        if (unstable !== u0)        begin errors++; $display("FAIL basic_stable: got %0d want %0d", unstable, u0); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL basic_idle: got %b want 0", busy); end
    endtask

    task automatic test_empty_stall();
        logic [7:0] want [6];
        int t0 = tx_n;
        int r0 = rd_n;
        int f0 = fd_n;
        want = '{8'hAA, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h55};
        send_cmd(8'h43);
        tick(500);
        checks += 6;
        if (tx_n - t0 !== 1)     begin errors++; $display("FAIL stall_tx: got %0d want 1", tx_n - t0); end
        if (tx_log[t0] !== 8'hAA) begin errors++; $display("FAIL stall_hdr: got %h want aa", tx_log[t0]); end
        if (rd_n !== r0)         begin errors++; $display("FAIL stall_reads: got %0d want %0d", rd_n, r0); end
        if (underflow !== 0)     begin errors++; $display("FAIL stall_underflow: got %0d want 0", underflow); end
        if (busy !== 1'b1)       begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
        if (capture_en !== 1'b1) begin errors++; $display("FAIL stall_cap: got %b want 1", capture_en); end
        push(8'hE1); push(8'hE2);
        tick(40);
        checks += 3;
        if (tx_n - t0 !== 3) begin errors++; $display("FAIL stall_resume_tx: got %0d want 3", tx_n - t0); end
        if (rd_n - r0 !== 2) begin errors++; $display("FAIL stall_resume_rd: got %0d want 2", rd_n - r0); end
        if (busy !== 1'b1)   begin errors++; $display("FAIL stall_resume_busy: got %b want 1", busy); end
        push(8'hE3); push(8'hE4);
        wait_done("stall", 200);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tx_log[t0+i] !== want[i]) begin
                errors++; $display("FAIL stall_byte%0d: got %h want %h", i, tx_log[t0+i], want[i]);
            end
        end
        checks += 2;
        if (fd_n - f0 !== 1) begin errors++; $display("FAIL stall_done: got %0d want 1", fd_n - f0); end
        if (underflow !== 0) begin errors++; $display("FAIL stall_underflow_end: got %0d want 0", underflow); end
    endtask

    task automatic test_abort();
        logic [7:0] want [4];
        int t0 = tx_n;
        int r0 = rd_n;
        int f0 = fd_n;
        want = '{8'hAA, 8'hA1, 8'hA2, 8'h55};
        tx_len = 20;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        send_cmd(8'h43);
        wait_tx("abort_wait_b2", t0 + 3, 300);
        send_cmd(8'h53);
        wait_done("abort", 300);
        checks += 3;
        if (tx_n - t0 !== 4) begin errors++; $display("FAIL abort_count: got %0d want 4", tx_n - t0); end
        if (rd_n - r0 !== 2) begin errors++; $display("FAIL abort_reads: got %0d want 2", rd_n - r0); end
        if (fd_n - f0 !== 1) begin errors++; $display("FAIL abort_done: got %0d want 1", fd_n - f0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_log[t0+i] !== want[i]) begin
                errors++; $display("FAIL abort_byte%0d: got %h want %h", i, tx_log[t0+i], want[i]);
            end
        end
        tx_len = 3;
    endtask

    task automatic test_ignored_cmds();
        logic [7:0] want [6];
        int t0 = tx_n;
        int r0 = rd_n;
        int f0;
        want = '{8'hAA, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'h55};
        send_cmd(8'h58);
        send_cmd(8'h53);
        tick(3);
        checks += 4;
        if (busy !== 1'b0)       begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        if (capture_en !== 1'b0) begin errors++; $display("FAIL idle_cap: got %b want 0", capture_en); end
        if (tx_n !== t0)         begin errors++; $display("FAIL idle_tx: got %0d want %0d", tx_n, t0); end
        if (rd_n !== r0)         begin errors++; $display("FAIL idle_rd: got %0d want %0d", rd_n, r0); end
        f0 = fd_n;
        push(8'hB1); push(8'hB2);
        send_cmd(8'h43);
        wait_tx("busy_cmd_wait", t0 + 2, 200);
        send_cmd(8'h43);
        wait_done("busy_cmd", 300);
        checks += 3;
        if (tx_n - t0 !== 6) begin errors++; $display("FAIL busy_cmd_count: got %0d want 6", tx_n - t0); end
        if (rd_n - r0 !== 4) begin errors++; $display("FAIL busy_cmd_reads: got %0d want 4", rd_n - r0); end
        if (fd_n - f0 !== 1) begin errors++; $display("FAIL busy_cmd_done: got %0d want 1", fd_n - f0); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tx_log[t0+i] !== want[i]) begin
                errors++; $display("FAIL busy_cmd_byte%0d: got %h want %h", i, tx_log[t0+i], want[i]);
            end
        end
        tick(5);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_cmd_idle: got %b want 0", busy); end
    endtask

    task automatic test_late_busy();
        logic [7:0] want [6];
        int t0 = tx_n;
        int r0 = rd_n;
        int s0 = start_busy;
        want = '{8'hAA, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h55};
        tx_delay = 1; tx_len = 3; chk_stable = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        send_cmd(8'h43);
        wait_done("late", 300);
        checks += 3;
        if (tx_n - t0 !== 6)   begin errors++; $display("FAIL late_count: got %0d want 6", tx_n - t0); end
        if (rd_n - r0 !== 4)   begin errors++; $display("FAIL late_reads: got %0d want 4", rd_n - r0); end
        if (start_busy !== s0) begin errors++; $display("FAIL late_start_busy: got %0d want %0d", start_busy, s0); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tx_log[t0+i] !== want[i]) begin
                errors++; $display("FAIL late_byte%0d: got %h want %h", i, tx_log[t0+i], want[i]);
            end
        end
        tx_delay = 0;
        chk_stable = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] want [6];
        int t0 = tx_n;
        int t1;
        int r1;
        int f1;
        want = '{8'hAA, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'h55};
        tx_len = 20;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        send_cmd(8'h43);
        wait_tx("rstmid_wait_b1", t0 + 2, 300);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks += 6;
        if (tx_start !== 1'b0)   begin errors++; $display("FAIL rstmid_tx_start: got %b want 0", tx_start); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b want 0", fifo_rd_en); end
        if (capture_en !== 1'b0) begin errors++; $display("FAIL rstmid_cap: got %b want 0", capture_en); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", frame_done); end
        if (tx_data !== 8'h00)   begin errors++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        tx_len = 3;
        push(8'hD5);
        t1 = tx_n; r1 = rd_n; f1 = fd_n;
        send_cmd(8'h43);
        wait_done("rstmid", 300);
        checks += 3;
        if (tx_n - t1 !== 6) begin errors++; $display("FAIL rstmid_count: got %0d want 6", tx_n - t1); end
        if (rd_n - r1 !== 4) begin errors++; $display("FAIL rstmid_reads: got %0d want 4", rd_n - r1); end
        if (fd_n - f1 !== 1) begin errors++; $display("FAIL rstmid_done_cnt: got %0d want 1", fd_n - f1); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tx_log[t1+i] !== want[i]) begin
                errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, tx_log[t1+i], want[i]);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic_frame();
        test_empty_stall();
        test_abort();
        test_ignored_cmds();
        test_late_busy();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
